decode_regfile: RTL

- Decode stage plus architectural register file, directly upstream of the execute stage of the multi-cycle 8-bit MIPS core.
- In the decode state it splits the fetched 32-bit instruction into fields and reads both source registers. It presents the operands, opcode, function code and immediate to execute, held stable through the following states.
- It also owns the register-file write port used by write-back. A debug read port is provided for verification.

---
 rtl/decode_regfile.sv | 119 +++++++++++
 1 files changed

// File: rtl/decode_regfile.sv
// Decode stage and architectural register file for the multi-cycle 8-bit MIPS core.
// Captures instruction fields and both source operands on the decode edge, then holds them for execute.
module decode_regfile #(
  parameter int DW   = 8,
  parameter int NREG = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    state,
  input  logic [31:0]   instr,
  input  logic          wb_en,
  input  logic [4:0]    wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] rsourcev,
  output logic [DW-1:0] rtempv,
  output logic [5:0]    opcode,
  output logic [5:0]    value_function,
  output logic [15:0]   immediate_value,
  output logic [4:0]    dest_addr,
  output logic          dest_valid,
  output logic          decode_done,
  input  logic [4:0]    dbg_addr,
  output logic [DW-1:0] dbg_data
);

  localparam logic [2:0] STATE_IF  = 3'd0;
  localparam logic [2:0] STATE_ID  = 3'd1;
  localparam logic [2:0] STATE_EX  = 3'd2;
  localparam logic [2:0] STATE_MEM = 3'd3;
  localparam logic [2:0] STATE_WB  = 3'd4;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] FUNC_ADDU = 6'h21;
  localparam logic [5:0] FUNC_SLT  = 6'h2a;

  logic [DW-1:0] rf [NREG];

  logic [4:0]    rs;
  logic [4:0]    rt;
  logic [4:0]    rd;
  logic          wb_fire;
  logic [DW-1:0] rs_val;
  logic [DW-1:0] rt_val;
  logic [4:0]    dest_nxt;
  logic          dest_valid_nxt;
  logic          unused_shamt;

  assign rs           = instr[25:21];
  assign rt           = instr[20:16];
  assign rd           = instr[15:11];
  assign unused_shamt = ^instr[10:6];
  assign wb_fire      = wb_en && (wb_addr != 5'd0);

  // Same-edge write-back wins over the stored value so decode never sees a stale operand.
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (rs != 5'd0) rs_val = (wb_fire && wb_addr == rs) ? wb_data : rf[rs];
    if (rt != 5'd0) rt_val = (wb_fire && wb_addr == rt) ? wb_data : rf[rt];
  end

  always_comb begin
    dest_nxt       = 5'd0;
    dest_valid_nxt = 1'b0;
    case (instr[31:26])
      OP_RTYPE: begin
        if (instr[5:0] == FUNC_ADDU || instr[5:0] == FUNC_SLT) begin
          dest_nxt       = rd;
          dest_valid_nxt = (rd != 5'd0);
        end
      end
      OP_ADDIU, OP_LW: begin
        dest_nxt       = rt;
        dest_valid_nxt = (rt != 5'd0);
      end
      OP_BEQ, OP_BNE: begin
        dest_nxt       = 5'd0;
        dest_valid_nxt = 1'b0;
      end
      default: begin
        dest_nxt       = 5'd0;
        dest_valid_nxt = 1'b0;
      end
    endcase
  end

  assign dbg_data = (dbg_addr == 5'd0) ? '0 : rf[dbg_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      rsourcev        <= '0;
      rtempv          <= '0;
      opcode          <= '0;
      value_function  <= '0;
      immediate_value <= '0;
      dest_addr       <= '0;
      dest_valid      <= 1'b0;
      decode_done     <= 1'b0;
    end else begin
      if (wb_fire) rf[wb_addr] <= wb_data;
      decode_done <= (state == STATE_ID);
      if (state == STATE_ID) begin
        rsourcev        <= rs_val;
        rtempv          <= rt_val;
        opcode          <= instr[31:26];
        value_function  <= instr[5:0];
        immediate_value <= instr[15:0];
        dest_addr       <= dest_nxt;
        dest_valid      <= dest_valid_nxt;
      end
    end
  end

endmodule
